// File: rtl/dsadc_pkg.sv
// Shared types and seven-segment encoding for the dual-slope ADC controller.
package dsadc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO,
        ST_INTEG,
        ST_DEINT,
        ST_LATCH
    } state_e;

    // Common-cathode glyphs, segment a in bit 6 down to g in bit 0.
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_ERR = 7'b1001111;

    function automatic logic [6:0] bcd_to_seg(logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_ERR;
        endcase
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Cascaded decimal counter: each digit wraps 9->0 and carries into the next
// when it and every lower digit hold 9.
module bcd_counter #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_s,
    input  logic                  clr,
    input  logic                  enb,
    output logic [4*DIGITS-1:0]   q,
    output logic                  all_nines
);

    logic [4*DIGITS-1:0] q_d;
    logic                ripple;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        q_d       = q;
        ripple    = enb;
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple) begin
                q_d[4*i +: 4] = (q[4*i +: 4] == 4'd9) ? 4'd0 : q[4*i +: 4] + 4'd1;
            end
            ripple    = ripple && (q[4*i +: 4] == 4'd9);
            all_nines = all_nines && (q[4*i +: 4] == 4'd9);
        end
        if (clr) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, integrate, de-integrate, latch, with
// registered switch drives, overflow flag and seven-segment result decode.
module dual_slope_ctrl
    import dsadc_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int T_ZERO = 4
) (
    input  logic                  clk,
    input  logic                  rst_s,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  vint_z,
    output logic                  ch_vm,
    output logic                  ch_vr,
    output logic                  ch_zr,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int ZW = (T_ZERO > 1) ? $clog2(T_ZERO) : 1;

    state_e              state_q, state_d;
    logic [ZW-1:0]       zcnt_q, zcnt_d;
    logic [4*DIGITS-1:0] count;
    logic                all_nines;
    logic                ch_vm_q, ch_vr_q, ch_zr_q, busy_q, done_q, ovf_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic                latch_now;

    bcd_counter #(.DIGITS(DIGITS)) u_counter (
        .clk       (clk),
        .rst_s     (rst_s),
        .clr       (state_q == ST_ZERO),
        .enb       ((state_q == ST_INTEG) || (state_q == ST_DEINT)),
        .q         (count),
        .all_nines (all_nines)
    );

    always_comb begin
        state_d = state_q;
        zcnt_d  = (state_q == ST_ZERO) ? zcnt_q + ZW'(1) : '0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ZERO;
            ST_ZERO:  if (zcnt_q == ZW'(T_ZERO - 1)) state_d = ST_INTEG;
            ST_INTEG: if (all_nines) state_d = ST_DEINT;
            ST_DEINT: if (vint_z || all_nines) state_d = ST_LATCH;
            ST_LATCH: state_d = cont ? ST_ZERO : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // At overflow the counter already holds all nines, so the count is the result either way.
    assign latch_now = (state_q == ST_DEINT) && (state_d == ST_LATCH);

    // Switches and handshakes decode the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q <= ST_IDLE;
            zcnt_q  <= '0;
            ch_vm_q <= 1'b0;
            ch_vr_q <= 1'b0;
            ch_zr_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            ch_vm_q <= (state_d == ST_INTEG);
            ch_vr_q <= (state_d == ST_DEINT);
            ch_zr_q <= (state_d == ST_ZERO);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_LATCH);
            if (latch_now) begin
                bcd_q <= count;
                ovf_q <= ~vint_z;
            end
        end
    end

    assign ch_vm = ch_vm_q;
    assign ch_vr = ch_vr_q;
    assign ch_zr = ch_zr_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign bcd   = bcd_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        assign seg[7*i +: 7] = bcd_to_seg(bcd_q[4*i +: 4]);
    end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Scoreboard bench for dual_slope_ctrl with DIGITS=2, T_ZERO=2 (full scale 100).
module tb_dual_slope_ctrl;

    localparam int DIGITS = 2;
    localparam int T_ZERO = 2;
    localparam int FS     = 100;

    logic        clk = 1'b0;
    logic        rst_s, start, cont, vint_z;
    logic        ch_vm, ch_vr, ch_zr, busy, done, ovf;
    logic [7:0]  bcd;
    logic [13:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] bcd;
        logic       ovf;
        int         zr_len;
        int         vm_len;
        int         vr_len;
        logic       next_zero;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dual_slope_ctrl #(.DIGITS(DIGITS), .T_ZERO(T_ZERO)) dut (
        .clk    (clk),
        .rst_s  (rst_s),
        .start  (start),
        .cont   (cont),
        .vint_z (vint_z),
        .ch_vm  (ch_vm),
        .ch_vr  (ch_vr),
        .ch_zr  (ch_zr),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .bcd    (bcd),
        .seg    (seg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b1001111;
        endcase
    endfunction

    function automatic exp_t mk(input logic [7:0] b, input logic o, input int vr, input logic nz);
        exp_t e;
        e.bcd = b; e.ovf = o; e.zr_len = T_ZERO; e.vm_len = FS; e.vr_len = vr; e.next_zero = nz;
        return e;
    endfunction

    // Monitor: phase lengths, switch exclusivity, and result checks on each done pulse.
    initial begin : monitor
        int   run_zr, run_vm, run_vr, last_zr, last_vm, last_vr;
        bit   after_done;
        exp_t cur;
        run_zr = 0; run_vm = 0; run_vr = 0;
        last_zr = 0; last_vm = 0; last_vr = 0;
        after_done = 1'b0;
        forever begin
            @(negedge clk);
            check("switch_exclusive", {31'b0, ($countones({ch_vm, ch_vr, ch_zr}) <= 1)}, 1);
            if (ch_zr) run_zr++; else if (run_zr != 0) begin last_zr = run_zr; run_zr = 0; end
            if (ch_vm) run_vm++; else if (run_vm != 0) begin last_vm = run_vm; run_vm = 0; end
            if (ch_vr) run_vr++; else if (run_vr != 0) begin last_vr = run_vr; run_vr = 0; end
            if (after_done) begin
                after_done = 1'b0;
                check("done_one_cycle", {31'b0, done}, 0);
                check("next_is_zero", {31'b0, ch_zr}, {31'b0, cur.next_zero});
                check("busy_after_latch", {31'b0, busy}, {31'b0, cur.next_zero});
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("bcd", {24'b0, bcd}, {24'b0, cur.bcd});
                    check("ovf", {31'b0, ovf}, {31'b0, cur.ovf});
                    check("seg", {18'b0, seg}, {18'b0, glyph(cur.bcd[7:4]), glyph(cur.bcd[3:0])});
                    check("zero_len", last_zr, cur.zr_len);
                    check("integ_len", last_vm, cur.vm_len);
                    check("deint_len", last_vr, cur.vr_len);
                    check("busy_in_latch", {31'b0, busy}, 1);
                    check("switches_off_in_latch", {29'b0, ch_vm, ch_vr, ch_zr}, 0);
                    after_done = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives the comparator: vint_z rises after k low DEINT cycles (k < 0: never).
    task automatic deint(input int k, input bit toggle);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (ch_vr) seen = 1'b1;
            else if (toggle && ch_vm) vint_z = ~vint_z;
        end
        if (!seen) begin
            check("deint_timeout", 1, 0);
            return;
        end
        vint_z = (k == 0);
        if (k > 0) begin
            repeat (k) @(negedge clk);
            vint_z = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("done_timeout", 1, 0);
        vint_z = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_s = 1'b1; start = 1'b0; cont = 1'b0; vint_z = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_switches", {29'b0, ch_vm, ch_vr, ch_zr}, 0);
        check("rst_flags", {29'b0, busy, done, ovf}, 0);
        check("rst_bcd", {24'b0, bcd}, 0);
        check("rst_seg", {18'b0, seg}, {18'b0, 14'b11111101111110});
        rst_s = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", {31'b0, busy}, 0);

        // Reset asserted mid-INTEG clears outputs without waiting for a clock edge.
        pulse_start();
        repeat (30) @(negedge clk);
        check("in_integ", {31'b0, ch_vm}, 1);
        @(posedge clk);
        #2 rst_s = 1'b1;
        #1;
        check("async_rst_switches", {29'b0, ch_vm, ch_vr, ch_zr}, 0);
        check("async_rst_flags", {29'b0, busy, done, ovf}, 0);
        check("async_rst_seg", {18'b0, seg}, {18'b0, 14'b11111101111110});
        @(negedge clk);
        rst_s = 1'b0;
        repeat (5) @(negedge clk);
        check("stay_idle", {28'b0, busy, ch_vm, ch_vr, ch_zr}, 0);

        // Nominal conversion.
        exp_q.push_back(mk(8'h37, 1'b0, 38, 1'b0));
        pulse_start();
        deint(37, 1'b0);
        repeat (3) @(negedge clk);

        // Zero input with comparator chatter during INTEG.
        exp_q.push_back(mk(8'h00, 1'b0, 1, 1'b0));
        pulse_start();
        deint(0, 1'b1);
        repeat (3) @(negedge clk);

        // Overflow: comparator never trips.
        exp_q.push_back(mk(8'h99, 1'b1, FS, 1'b0));
        pulse_start();
        deint(-1, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf_held", {31'b0, ovf}, 1);

        // Continuous mode, stray start pulses, cont dropped during the second conversion.
        cont = 1'b1;
        exp_q.push_back(mk(8'h12, 1'b0, 13, 1'b1));
        exp_q.push_back(mk(8'h58, 1'b0, 59, 1'b0));
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        deint(12, 1'b0);
        repeat (50) @(negedge clk);
        pulse_start();
        cont = 1'b0;
        deint(58, 1'b0);
        repeat (5) @(negedge clk);
        check("final_idle", {31'b0, busy}, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
